// File: rtl/laser_rx_deframer.sv
// laser_rx_deframer: receive-side packet deframer for the laser link.
//
// Hunts for a 4-byte sync word in the receiver byte stream, parses an
// 11-bit length header and forwards payload bytes cut-through to the FTDI
// write queue. It then checks the trailing 8-bit checksum and reports the
// frame outcome as a one-cycle pkt_ok / pkt_fail pulse.
//
// Frame: SYNC[31:24] SYNC[23:16] SYNC[15:8] SYNC[7:0] LEN_HI LEN_LO payload CHK
// CHK = (LEN_HI + LEN_LO + sum(payload)) mod 256
//
// Ports:
//   clock      - single clock
//   reset      - synchronous, active-high
//   en         - block enable; low forces HUNT and discards input
//   data_valid - receiver byte strobe
//   data_in    - receiver byte
//   wrq_full   - FTDI write queue full (payload byte is dropped when high)
//   wrreq      - write strobe to the FTDI write queue
//   data_wr    - payload byte for the write queue
//   pkt_ok     - frame accepted (one-cycle pulse)
//   pkt_fail   - frame rejected (one-cycle pulse)
//   fail_code  - 0 bad length, 1 checksum, 2 timeout, 3 overflow
//   pkt_len    - length field of the most recently parsed header
//   busy       - high unless in HUNT with sync index 0
module laser_rx_deframer #(
    parameter logic [31:0] SYNC    = 32'hd1d2d3d4,
    parameter int          MAX_LEN = 1024,
    parameter int          TIMEOUT = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        data_valid,
    input  logic [7:0]  data_in,
    input  logic        wrq_full,
    output logic        wrreq,
    output logic [7:0]  data_wr,
    output logic        pkt_ok,
    output logic        pkt_fail,
    output logic [1:0]  fail_code,
    output logic [10:0] pkt_len,
    output logic        busy
);
    localparam int              TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TIMEOUT_C = TW'(TIMEOUT);
    localparam logic [11:0]     MAX_LEN_C = 12'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT, S_LEN_HI, S_LEN_LO, S_PAYLOAD, S_CHECK
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    len_hi_q, len_hi_d;
    logic [10:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          wrreq_q, wrreq_d;
    logic [7:0]    data_wr_q, data_wr_d;
    logic          pkt_ok_q, pkt_ok_d;
    logic          pkt_fail_q, pkt_fail_d;
    logic [1:0]    fail_code_q, fail_code_d;
    logic [10:0]   pkt_len_q, pkt_len_d;
    logic          busy_q, busy_d;

    logic [7:0]  sync_byte;
    logic [10:0] length;
    logic        len_bad;
    logic        in_hunt0;

    always_comb begin
        case (idx_q)
            2'd0:    sync_byte = SYNC[31:24];
            2'd1:    sync_byte = SYNC[23:16];
            2'd2:    sync_byte = SYNC[15:8];
            default: sync_byte = SYNC[7:0];
        endcase
    end

    // Only the low 11 bits carry length; any of LEN_HI[7:3] set is illegal.
    assign length   = {len_hi_q[2:0], data_in};
    assign len_bad  = (len_hi_q[7:3] != 5'd0) || (length == 11'd0) ||
                      ({1'b0, length} > MAX_LEN_C);
    assign in_hunt0 = (state_q == S_HUNT) && (idx_q == 2'd0);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        len_hi_d    = len_hi_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        wrreq_d     = 1'b0;
        data_wr_d   = data_wr_q;
        pkt_ok_d    = 1'b0;
        pkt_fail_d  = 1'b0;
        fail_code_d = fail_code_q;
        pkt_len_d   = pkt_len_q;

        // Idle counter only runs once something has been matched.
        if (in_hunt0 || data_valid) idle_d = '0;
        else                        idle_d = idle_q + 1'b1;

        if (!en) begin
            state_d = S_HUNT;
            idx_d   = 2'd0;
            sum_d   = 8'd0;
            cnt_d   = 11'd0;
            ovf_d   = 1'b0;
            idle_d  = '0;
        end else if (!in_hunt0 && idle_q == TIMEOUT_C) begin
            // Partial sync is dropped silently; a started frame reports.
            if (state_q != S_HUNT) begin
                pkt_fail_d  = 1'b1;
                fail_code_d = 2'd2;
            end
            state_d = S_HUNT;
            idx_d   = 2'd0;
            sum_d   = 8'd0;
            cnt_d   = 11'd0;
            ovf_d   = 1'b0;
            idle_d  = '0;
        end else if (data_valid) begin
            case (state_q)
                S_HUNT: begin
                    if (data_in == sync_byte) begin
                        if (idx_q == 2'd3) begin
                            state_d = S_LEN_HI;
                            idx_d   = 2'd0;
                            sum_d   = 8'd0;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else begin
                        // Sync bytes are distinct, so a mismatch can only
                        // restart on the first sync byte.
                        idx_d = (data_in == SYNC[31:24]) ? 2'd1 : 2'd0;
                    end
                end
                S_LEN_HI: begin
                    len_hi_d = data_in;
                    sum_d    = sum_q + data_in;
                    state_d  = S_LEN_LO;
                end
                S_LEN_LO: begin
                    sum_d     = sum_q + data_in;
                    pkt_len_d = length;
                    if (len_bad) begin
                        pkt_fail_d  = 1'b1;
                        fail_code_d = 2'd0;
                        state_d     = S_HUNT;
                    end else begin
                        cnt_d   = length;
                        ovf_d   = 1'b0;
                        state_d = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    sum_d = sum_q + data_in;
                    cnt_d = cnt_q - 11'd1;
                    if (wrq_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        wrreq_d   = 1'b1;
                        data_wr_d = data_in;
                    end
                    if (cnt_q == 11'd1) state_d = S_CHECK;
                end
                S_CHECK: begin
                    if (ovf_q) begin
                        pkt_fail_d  = 1'b1;
                        fail_code_d = 2'd3;
                    end else if (data_in != sum_q) begin
                        pkt_fail_d  = 1'b1;
                        fail_code_d = 2'd1;
                    end else begin
                        pkt_ok_d = 1'b1;
                    end
                    ovf_d   = 1'b0;
                    state_d = S_HUNT;
                end
                default: state_d = S_HUNT;
            endcase
        end

        busy_d = !((state_d == S_HUNT) && (idx_d == 2'd0));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_HUNT;
            idx_q       <= 2'd0;
            sum_q       <= 8'd0;
            len_hi_q    <= 8'd0;
            cnt_q       <= 11'd0;
            ovf_q       <= 1'b0;
            idle_q      <= '0;
            wrreq_q     <= 1'b0;
            data_wr_q   <= 8'd0;
            pkt_ok_q    <= 1'b0;
            pkt_fail_q  <= 1'b0;
            fail_code_q <= 2'd0;
            pkt_len_q   <= 11'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            len_hi_q    <= len_hi_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            idle_q      <= idle_d;
            wrreq_q     <= wrreq_d;
            data_wr_q   <= data_wr_d;
            pkt_ok_q    <= pkt_ok_d;
            pkt_fail_q  <= pkt_fail_d;
            fail_code_q <= fail_code_d;
            pkt_len_q   <= pkt_len_d;
            busy_q      <= busy_d;
        end
    end

    assign wrreq     = wrreq_q;
    assign data_wr   = data_wr_q;
    assign pkt_ok    = pkt_ok_q;
    assign pkt_fail  = pkt_fail_q;
    assign fail_code = fail_code_q;
    assign pkt_len   = pkt_len_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_laser_rx_deframer.sv
// Self-checking bench for laser_rx_deframer: table-driven frames, directed
// multi-cycle corner cases, and randomized frames checked against a
// frame-level model built from how each frame was constructed.
module tb_laser_rx_deframer;
    localparam int TO = 16;
    localparam int ML = 1024;

    logic        clock = 1'b0;
    logic        reset, en, data_valid, wrq_full;
    logic [7:0]  data_in;
    logic        wrreq, pkt_ok, pkt_fail, busy;
    logic [7:0]  data_wr;
    logic [1:0]  fail_code;
    logic [10:0] pkt_len;

    laser_rx_deframer #(.SYNC(32'hd1d2d3d4), .MAX_LEN(ML), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .en(en), .data_valid(data_valid),
        .data_in(data_in), .wrq_full(wrq_full), .wrreq(wrreq), .data_wr(data_wr),
        .pkt_ok(pkt_ok), .pkt_fail(pkt_fail), .fail_code(fail_code),
        .pkt_len(pkt_len), .busy(busy)
    );

    always #5 clock = ~clock;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    // Event record: {kind (1 ok, 2 fail), code, pkt_len}
    logic [7:0]  got_wr[$];
    logic [14:0] got_ev[$];
    logic [7:0]  exp_wr[$];
    logic [14:0] exp_ev[$];

    typedef struct {
        logic [95:0] b;      // bytes, first byte in the MSBs
        int          n;
        logic [11:0] fmask;  // wrq_full per byte index
        int          ev;     // 1 ok, 2 fail
        logic [1:0]  code;
        int          nwr;
        logic [31:0] wr;     // expected writes, first in the MSBs
        logic [10:0] len;
    } vec_t;

    vec_t tbl[8];

    function automatic vec_t mk(input logic [95:0] b, input int n, input logic [11:0] fm,
                                input int ev, input logic [1:0] code, input int nwr,
                                input logic [31:0] wr, input logic [10:0] len);
        vec_t v;
        v.b = b; v.n = n; v.fmask = fm; v.ev = ev; v.code = code;
        v.nwr = nwr; v.wr = wr; v.len = len;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tot_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    always @(negedge clock) begin
        if (wrreq === 1'b1) got_wr.push_back(data_wr);
        if (pkt_ok === 1'b1 || pkt_fail === 1'b1)
            got_ev.push_back({(pkt_ok === 1'b1) ? 2'd1 : 2'd2,
                              (pkt_fail === 1'b1) ? fail_code : 2'd0, pkt_len});
        if (pkt_ok === 1'b1 && pkt_fail === 1'b1) begin
            tot_cnt++;
            $display("FAIL exclusive pulses: ok=1 fail=1, at most one required");
        end
    end

    task automatic send(input logic [7:0] b, input logic full);
        data_valid = 1'b1; data_in = b; wrq_full = full;
        @(negedge clock);
        data_valid = 1'b0; wrq_full = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Occasional idle gap (always shorter than the timeout) before a byte.
    task automatic rsend(input logic [7:0] b, input logic full);
        if ($urandom_range(0, 7) == 0) idle($urandom_range(1, TO - 1));
        send(b, full);
    endtask

    task automatic send_vec(input vec_t v);
        for (int i = 0; i < v.n; i++) send(v.b[8*(11-i) +: 8], v.fmask[i]);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        got_wr.delete(); got_ev.delete();
        send_vec(v);
        chk({nm, " ok timing"}, {31'd0, pkt_ok}, {31'd0, v.ev == 1});
        chk({nm, " fail timing"}, {31'd0, pkt_fail}, {31'd0, v.ev == 2});
        idle(2);
        chk({nm, " event count"}, got_ev.size(), 1);
        if (got_ev.size() > 0)
            chk({nm, " event"}, {17'd0, got_ev[0]},
                {17'd0, (v.ev == 1) ? {2'd1, 2'd0, v.len} : {2'd2, v.code, v.len}});
        chk({nm, " write count"}, got_wr.size(), v.nwr);
        for (int i = 0; i < v.nwr && i < got_wr.size(); i++)
            chk({nm, " write data"}, {24'd0, got_wr[i]}, {24'd0, v.wr[8*(3-i) +: 8]});
        chk({nm, " busy idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic send_sync;
        send(8'hd1, 1'($urandom)); send(8'hd2, 1'($urandom));
        send(8'hd3, 1'($urandom)); send(8'hd4, 1'($urandom));
    endtask

    initial begin
        int k;
        tbl[0] = mk(96'hd1d2d3d4_0003_112233_69_0000, 10, 12'h000, 1, 2'd0, 3, 32'h11223300, 11'd3);
        tbl[1] = mk(96'hd1d2d3d4_0003_112233_6a_0000, 10, 12'h000, 2, 2'd1, 3, 32'h11223300, 11'd3);
        tbl[2] = mk(96'hd1d2d3d4_0000_000000000000,    6, 12'h000, 2, 2'd0, 0, 32'h0, 11'd0);
        tbl[3] = mk(96'hd1d2d3d4_0401_000000000000,    6, 12'h000, 2, 2'd0, 0, 32'h0, 11'h401);
        tbl[4] = mk(96'hd1d2d3d4_0801_000000000000,    6, 12'h000, 2, 2'd0, 0, 32'h0, 11'h001);
        tbl[5] = mk(96'hd1d2d3d4_0003_112233_69_0000, 10, 12'h080, 2, 2'd3, 2, 32'h11330000, 11'd3);
        tbl[6] = mk(96'hd1d1d2d3d4_0001_aaab_000000,   9, 12'h000, 1, 2'd0, 1, 32'haa000000, 11'd1);
        tbl[7] = mk(96'hd1d2d3d4_0003_112233_6a_0000, 10, 12'h040, 2, 2'd3, 2, 32'h22330000, 11'd3);

        reset = 1'b1; en = 1'b1; data_valid = 1'b0; wrq_full = 1'b0; data_in = 8'h00;
        idle(2);
        chk("reset wrreq", {31'd0, wrreq}, 0);
        chk("reset data_wr", {24'd0, data_wr}, 0);
        chk("reset pkt_ok", {31'd0, pkt_ok}, 0);
        chk("reset pkt_fail", {31'd0, pkt_fail}, 0);
        chk("reset fail_code", {30'd0, fail_code}, 0);
        chk("reset pkt_len", {21'd0, pkt_len}, 0);
        chk("reset busy", {31'd0, busy}, 0);
        reset = 1'b0;
        idle(1);

        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back: resync frame then good frame with no gap.
        got_wr.delete(); got_ev.delete();
        send_vec(tbl[6]); send_vec(tbl[0]);
        idle(2);
        chk("b2b event count", got_ev.size(), 2);
        if (got_ev.size() == 2) begin
            chk("b2b ev0", {17'd0, got_ev[0]}, {17'd0, 2'd1, 2'd0, 11'd1});
            chk("b2b ev1", {17'd0, got_ev[1]}, {17'd0, 2'd1, 2'd0, 11'd3});
        end
        chk("b2b write count", got_wr.size(), 4);
        if (got_wr.size() == 4)
            chk("b2b writes", {got_wr[0], got_wr[1], got_wr[2], got_wr[3]}, 32'haa112233);

        // Frame timeout mid-payload.
        got_wr.delete(); got_ev.delete();
        send_sync; send(8'h00, 0); send(8'h03, 0); send(8'h11, 0); send(8'h22, 0);
        k = 0;
        while (pkt_fail !== 1'b1 && k < 4 * TO) begin @(negedge clock); k++; end
        chk("timeout latency", k, TO + 1);
        chk("timeout code", {30'd0, fail_code}, 2);
        chk("timeout busy", {31'd0, busy}, 0);
        idle(2);
        run_vec(tbl[0], "post-timeout");

        // Partial sync times out silently.
        got_ev.delete();
        send(8'hd1, 0); send(8'hd2, 0);
        chk("hunt busy", {31'd0, busy}, 1);
        idle(TO + 3);
        chk("hunt timeout busy", {31'd0, busy}, 0);
        chk("hunt timeout silent", got_ev.size(), 0);
        run_vec(tbl[0], "post-hunt-timeout");

        // Reset mid-payload.
        send_sync; send(8'h00, 0); send(8'h03, 0); send(8'h11, 0); send(8'h22, 0);
        got_ev.delete();
        reset = 1'b1; idle(1); reset = 1'b0;
        chk("rst wrreq", {31'd0, wrreq}, 0);
        chk("rst data_wr", {24'd0, data_wr}, 0);
        chk("rst pkt_len", {21'd0, pkt_len}, 0);
        chk("rst busy", {31'd0, busy}, 0);
        chk("rst pulses", {30'd0, pkt_ok, pkt_fail}, 0);
        idle(3);
        chk("rst silent", got_ev.size(), 0);
        run_vec(tbl[0], "post-reset");

        // Enable low mid-frame: abort silently, remaining bytes ignored.
        got_ev.delete();
        send_sync; send(8'h00, 0); send(8'h03, 0); send(8'h11, 0);
        en = 1'b0; idle(1);
        chk("en-low busy", {31'd0, busy}, 0);
        send(8'hd1, 0);
        chk("en-low ignores input", {31'd0, busy}, 0);
        en = 1'b1;
        send(8'h22, 0); send(8'h33, 0); send(8'h69, 0); idle(2);
        chk("en-low silent", got_ev.size(), 0);
        run_vec(tbl[0], "post-en");

        // Randomized frames vs. frame-level model.
        got_wr.delete(); got_ev.delete(); exp_wr.delete(); exp_ev.delete();
        for (int f = 0; f < 40; f++) begin
            int          kind, len;
            logic [7:0]  hi, lo, s, b, c;
            logic        full, any_full;
            kind = (f == 0) ? 0 : $urandom_range(0, 3);
            repeat ($urandom_range(0, 3)) begin
                b = 8'($urandom);
                if (b == 8'hd1) b = 8'h00;
                rsend(b, 1'($urandom));
            end
            if (kind == 2) begin
                case ($urandom_range(0, 2))
                    0:       begin hi = 8'h00; lo = 8'h00; end
                    1:       begin len = $urandom_range(ML + 1, 2047); hi = 8'(len >> 8); lo = 8'(len); end
                    default: begin hi = {5'($urandom_range(1, 31)), 3'($urandom)}; lo = 8'($urandom); end
                endcase
                send_sync; rsend(hi, 0); rsend(lo, 0);
                exp_ev.push_back({2'd2, 2'd0, hi[2:0], lo});
            end else begin
                len = (f == 0) ? ML : $urandom_range(1, 12);
                hi = 8'(len >> 8); lo = 8'(len);
                s = 8'((int'(hi) + int'(lo)) % 256);
                any_full = 1'b0;
                send_sync; rsend(hi, 1'($urandom)); rsend(lo, 1'($urandom));
                for (int i = 0; i < len; i++) begin
                    b = 8'($urandom);
                    full = (kind == 3) && ($urandom_range(0, 3) == 0 || (i == len - 1 && !any_full));
                    s = 8'((int'(s) + int'(b)) % 256);
                    if (full) any_full = 1'b1;
                    else exp_wr.push_back(b);
                    rsend(b, full);
                end
                if (kind == 1 || (kind == 3 && $urandom_range(0, 1) == 1))
                    c = 8'((int'(s) + $urandom_range(1, 255)) % 256);
                else
                    c = s;
                rsend(c, 1'($urandom));
                if (kind == 3)      exp_ev.push_back({2'd2, 2'd3, 11'(len)});
                else if (kind == 1) exp_ev.push_back({2'd2, 2'd1, 11'(len)});
                else                exp_ev.push_back({2'd1, 2'd0, 11'(len)});
            end
        end
        idle(TO);
        chk("rand event count", got_ev.size(), exp_ev.size());
        for (int i = 0; i < exp_ev.size() && i < got_ev.size(); i++)
            chk($sformatf("rand event %0d", i), {17'd0, got_ev[i]}, {17'd0, exp_ev[i]});
        chk("rand write count", got_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            chk($sformatf("rand write %0d", i), {24'd0, got_wr[i]}, {24'd0, exp_wr[i]});

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule

// File: doc/laser_rx_deframer.md
# laser_rx_deframer

Receive-side packet deframer for the laser link. It sits directly downstream of the laser receiver and consumes its `data_valid`/`data_in` byte stream. It hunts for the DATA sync word, parses a length header, forwards payload bytes into the FTDI write queue, and checks a trailing checksum. It reports each packet's outcome as a one-cycle `pkt_ok` or `pkt_fail` pulse; the ACK/FAIL response logic uses that pulse.

## Interface

Parameters:
- `SYNC`, default `32'hd1d2d3d4`: sync word, sent MSB byte first. All four bytes must be distinct.
- `MAX_LEN`, default `1024`: largest legal payload length in bytes.
- `TIMEOUT`, default `1024`: number of idle clocks (no `data_valid`) mid-frame before the frame is abandoned.

Ports:
- `clock  in  1`: single clock for all logic.
- `reset  in  1`: synchronous, active-high.
- `en  in  1`: block enable; low forces HUNT.
- `data_valid  in  1`: receiver byte strobe, one cycle per byte.
- `data_in  in  8`: receiver byte; valid only when `data_valid` is high.
- `wrq_full  in  1`: FTDI write queue full.
- `wrreq  out  1`: write strobe to the FTDI write queue.
- `data_wr  out  8`: payload byte for the write queue.
- `pkt_ok  out  1`: one-cycle pulse; frame accepted.
- `pkt_fail  out  1`: one-cycle pulse; frame rejected.
- `fail_code  out  2`: failure reason, valid with `pkt_fail`. 0 = bad length, 1 = checksum, 2 = timeout, 3 = overflow.
- `pkt_len  out  11`: length field of the most recently parsed header.
- `busy  out  1`: high whenever the block is not in HUNT with sync index 0.

## Operation

- Frame format: SYNC[31:24], SYNC[23:16], SYNC[15:8], SYNC[7:0], LEN_HI, LEN_LO, LEN payload bytes, CHK.
- CHK is the 8-bit sum, modulo 256, of LEN_HI, LEN_LO and every payload byte.
- States: HUNT(idx 0..3), LEN_HI, LEN_LO, PAYLOAD, CHECK. Transitions are evaluated only on cycles where `data_valid` is high, except for timeout, `en` and reset.
- HUNT, byte matches SYNC byte[idx]:
  - idx < 3: idx increments.
  - idx = 3: go to LEN_HI and clear the running sum.
- HUNT, byte mismatches: idx becomes 1 if the byte equals SYNC[31:24], otherwise 0. Example: d1 d1 d2 d3 d4 is accepted.
- LEN_HI and LEN_LO: each byte is added to the running sum. On LEN_LO, length = {LEN_HI, LEN_LO}[10:0] and `pkt_len` is updated.
  - Length is illegal if LEN_HI[7:3] is nonzero, if length is 0, or if length > MAX_LEN.
  - Illegal length: `pkt_fail` with code 0, then HUNT.
  - Legal length: go to PAYLOAD with the remaining-byte counter set to length.
- PAYLOAD: each byte is added to the sum and the counter decrements.
  - If `wrq_full` is low, the byte is forwarded.
  - If `wrq_full` is high, the byte is dropped and a sticky overflow flag is set.
  - When the counter reaches 0, go to CHECK.
- CHECK, on the CHK byte: report the result, then return to HUNT.
  - Overflow flag set: `pkt_fail` with code 3. Overflow takes priority over checksum.
  - Else CHK differs from the running sum: `pkt_fail` with code 1.
  - Else: `pkt_ok`.
- Payload is forwarded cut-through. On a failed frame the bytes already forwarded stay in the queue; software discards them on FAIL.
- Timeout: an idle counter clears on every `data_valid` and increments otherwise, in every state except HUNT idx 0. When it reaches TIMEOUT:
  - In LEN_HI, LEN_LO, PAYLOAD or CHECK: `pkt_fail` with code 2, then HUNT.
  - In HUNT idx > 0: idx resets to 0 silently, with no pulse.
- `en` low: go to HUNT idx 0 immediately. No pulse. Overflow flag, sum and counters clear. Incoming bytes are ignored.
- At most one of `pkt_ok` and `pkt_fail` is high in any cycle.

## Timing

- All outputs are registered.
- Reset values: `wrreq`=0, `data_wr`=0, `pkt_ok`=0, `pkt_fail`=0, `fail_code`=0, `pkt_len`=0, `busy`=0; state HUNT idx 0.
- Reset mid-frame aborts the frame with no pulse. Outputs read reset values on the cycle after reset is sampled.
- `wrreq` and `data_wr` assert exactly one cycle after the payload byte's `data_valid`, and `wrreq` lasts one cycle. `wrq_full` is sampled in the same cycle as `data_valid`.
- `pkt_ok` and `pkt_fail` assert one cycle after the `data_valid` of the CHK byte, or of LEN_LO for a bad length.
- A timeout pulse asserts one cycle after the idle counter equals TIMEOUT.
- `pkt_len` updates one cycle after LEN_LO and holds until the next header.
- A sync byte arriving on the cycle right after CHK is accepted (back-to-back frames). The state has already returned to HUNT.
- Idle clocks between bytes are allowed anywhere in the frame, up to TIMEOUT-1 consecutive.

## Test plan

- Good frame: d1 d2 d3 d4 00 03 11 22 33 69 → `wrreq` pulses carrying 11, 22, 33; `pkt_len`=3; `pkt_ok` one cycle after byte 69; `pkt_fail` never asserts.
- Bad checksum: same frame but CHK=6a → 11, 22, 33 forwarded; `pkt_fail` with `fail_code`=1; `pkt_ok` stays low.
- Bad length: d1 d2 d3 d4 00 00, then d1 d2 d3 d4 04 01 → each header gives `pkt_fail` code 0; no `wrreq`; block returns to HUNT.
- Resync and back-to-back: d1 d1 d2 d3 d4 00 01 aa ab, immediately followed by the good frame above → two `pkt_ok` pulses; `data_wr` sequence aa, 11, 22, 33.
- Timeout: header 00 03, then 11 22, then idle → `pkt_fail` code 2 exactly TIMEOUT+1 cycles after byte 22; `busy` goes low; a subsequent good frame is accepted.
- Overflow and reset: good frame with `wrq_full` high during byte 22 → only 11 and 33 forwarded; `pkt_fail` code 3. Repeat with reset asserted during payload → no pulse; all outputs 0; next frame accepted.
